operand_fetch: RTL
==================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: none; data width SHALL be fixed at 16 bits and register count at 8.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to fetch one operand pair; sampled only when busy=0.
REQ-005 rn  input  3  register index for operand A.
REQ-006 rm  input  3  register index for operand B.
REQ-007 shift  input  2  B shift code: 00 none, 01 left 1 with 0 fill, 10 logical right 1, 11 arithmetic right 1 (msb copied).
REQ-008 asel  input  1  when 1, Ain SHALL be 16'h0000 instead of A.
REQ-009 bsel  input  1  when 1, Bin SHALL be sximm5 instead of shifted B.
REQ-010 sximm5  input  16  sign-extended immediate.
REQ-011 wr_en  input  1  register-file write enable.
REQ-012 wr_num  input  3  register-file write index.
REQ-013 wr_data  input  16  register-file write data, typically the ALU result.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 out_valid  output  1  Ain/Bin hold a valid pair.
REQ-016 out_ready  input  1  consumer (ALU stage) accepts the pair.
REQ-017 Ain  output  16  operand A to the ALU.
REQ-018 Bin  output  16  operand B to the ALU.

Function
REQ-019 FSM states SHALL be IDLE, READ_A, READ_B, and VALID.
REQ-020 Transitions SHALL be: IDLE->READ_A on start; READ_A->READ_B; READ_B->VALID; VALID->IDLE when out_ready=1; VALID holds while out_ready=0.
REQ-021 On the start-accept edge, rn, rm, shift, asel, bsel, and sximm5 SHALL be captured; later changes to these inputs SHALL have no effect on the current pair.
REQ-022 In READ_A, the A register SHALL load R[rn_captured] at the end of the cycle; in READ_B, the B register SHALL load R[rm_captured] likewise.
REQ-023 The register file SHALL have one read port; exactly one read SHALL occur per cycle, which is why operand fetch takes two cycles.
REQ-024 out_valid SHALL be 1 only in VALID.
REQ-025 Latency SHALL be exactly 3 cycles from the start-accept edge to out_valid=1.
REQ-026 Ain SHALL equal asel ? 0 : A, and Bin SHALL equal bsel ? sximm5 : shift(B), both computed from captured controls.
REQ-027 Ain and Bin SHALL be stable throughout VALID.
REQ-028 Ain and Bin are don't-care outside VALID, but SHALL never be X after reset.
REQ-029 Shift results SHALL be truncated to 16 bits with no carry-out.
REQ-030 Writes SHALL occur on any clock edge in any state when wr_en=1: R[wr_num] <= wr_data.
REQ-031 For a write to the register being read on the same edge, the loaded operand SHALL be the old value, with no forwarding.
REQ-032 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-033 A pair accepted (out_ready=1 in VALID) SHALL return the FSM to IDLE on the next edge; a start in that same cycle SHALL be ignored, and the earliest new accept SHALL be the following cycle.

Reset
REQ-034 Asserting reset at any time, including mid-fetch, SHALL immediately force IDLE, and SHALL clear the A and B registers, the captured controls, and all 8 registers to 16'h0000.
REQ-035 During reset, busy=0, out_valid=0, Ain=0, and Bin=0.
REQ-036 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the 2-bit shift-code constants, and the width and register-count constants.
REQ-038 The shifter SHALL be a separate combinational sub-module, shifter16 (16-bit in, 2-bit code, 16-bit out).
REQ-039 The register file SHALL remain inside operand_fetch.

Verification
REQ-040 Write R2=16'h0007 and R5=16'h0003; start with rn=2, rm=5, shift=00, asel=0, bsel=0 -> out_valid on the 3rd edge after accept, with Ain=0007 and Bin=0003.
REQ-041 Set R1=16'h8001; fetch B=R1 with each shift code -> Bin is 8001, 0002, 4000, and C000 respectively.
REQ-042 asel=1, bsel=1, sximm5=16'hFFF0 -> Ain=0000 and Bin=FFF0 regardless of register contents.
REQ-043 Hold out_ready=0 for 5 cycles while changing rn, rm, and sximm5 -> out_valid stays 1 with Ain and Bin unchanged; a start pulse is ignored; out_ready=1 -> IDLE next edge.
REQ-044 Write R3=16'hAAAA on the same edge READ_A reads R3 (old value 16'h1111) -> Ain=1111, and a subsequent fetch returns AAAA.
REQ-045 Assert reset during READ_B -> busy=0, out_valid=0, and all registers read 0000 on the next fetch.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: widths, shift codes,
// FSM state encoding and the captured per-pair control bundle.
package operand_fetch_pkg;

    localparam int DATA_W = 16;
    localparam int REG_N  = 8;
    localparam int IDX_W  = 3;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ_A = 2'd1,
        ST_READ_B = 2'd2,
        ST_VALID  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [IDX_W-1:0]  rn;
        logic [IDX_W-1:0]  rm;
        logic [1:0]        shift;
        logic              asel;
        logic              bsel;
        logic [DATA_W-1:0] sximm5;
    } fetch_ctrl_t;

endpackage

// File: rtl/operand_fetch_shifter16.sv
// Combinational single-bit shifter for operand B; the result is truncated
// to 16 bits, so the bit shifted out is simply dropped.
module shifter16
    import operand_fetch_pkg::*;
(
    input  logic [DATA_W-1:0] in_i,
    input  logic [1:0]        code_i,
    output logic [DATA_W-1:0] out_o
);

    always_comb begin
        out_o = in_i;
        case (code_i)
            SH_NONE: out_o = in_i;
            SH_LSL:  out_o = {in_i[DATA_W-2:0], 1'b0};
            SH_LSR:  out_o = {1'b0, in_i[DATA_W-1:1]};
            SH_ASR:  out_o = {in_i[DATA_W-1], in_i[DATA_W-1:1]};
            default: out_o = in_i;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: an 8x16 register file with a single read port, read over
// two cycles (A then B) into holding registers that feed the ALU.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [IDX_W-1:0]   rn,
    input  logic [IDX_W-1:0]   rm,
    input  logic [1:0]         shift,
    input  logic               asel,
    input  logic               bsel,
    input  logic [DATA_W-1:0]  sximm5,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_num,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  Ain,
    output logic [DATA_W-1:0]  Bin,
    output fetch_state_e       dbg_state
);

    // Handshake: a pair transfers on a rising edge where out_valid and
    // out_ready are both 1; out_valid never drops and Ain/Bin never change
    // until that edge. start is only sampled while busy is 0.

    fetch_state_e       state_q, state_d;
    fetch_ctrl_t        ctrl_q, ctrl_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  rf_q [REG_N];
    logic [IDX_W-1:0]   rd_idx;
    logic [DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]  b_shifted;

    // Single read port: the index is steered by which operand is being read.
    assign rd_idx  = (state_q == ST_READ_A) ? ctrl_q.rn : ctrl_q.rm;
    assign rd_data = rf_q[rd_idx];

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ_A;
                    ctrl_d  = '{rn: rn, rm: rm, shift: shift, asel: asel,
                                bsel: bsel, sximm5: sximm5};
                end
            end
            ST_READ_A: begin
                a_d     = rd_data;
                state_d = ST_READ_B;
            end
            ST_READ_B: begin
                b_d     = rd_data;
                state_d = ST_VALID;
            end
            ST_VALID: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Writes never forward: a read on the same edge sees the old contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
        end else if (wr_en) begin
            rf_q[wr_num] <= wr_data;
        end
    end

    shifter16 u_shifter (
        .in_i   (b_q),
        .code_i (ctrl_q.shift),
        .out_o  (b_shifted)
    );

    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_VALID);
    assign Ain       = ctrl_q.asel ? '0 : a_q;
    assign Bin       = ctrl_q.bsel ? ctrl_q.sximm5 : b_shifted;
    assign dbg_state = state_q;

endmodule
